// File: rtl/pio_evt_pkg.sv
// Shared types for the PIO event sequencer: FSM state encoding and PIO register map.
package pio_evt_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    RD_EDGE,
    CAP_EDGE,
    CLR_EDGE,
    RD_DATA,
    CAP_DATA
  } state_t;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

endpackage

// File: rtl/pio_evt_fifo.sv
// First-word-fall-through event FIFO; head is shown combinationally and forced to zero when empty.
module pio_evt_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside it.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pio_event_sequencer.sv
// Avalon-MM master that services an edge-capturing PIO and queues {edges, data} events.
// Optional macro PIO_EVT_TIMESTAMP_EN adds a 16-bit cycle timestamp per event (evt_time).
module pio_event_sequencer
  import pio_evt_pkg::*;
#(
  parameter int               WIDTH      = 10,
  parameter logic [WIDTH-1:0] IRQ_MASK   = 10'h3FF,
  parameter int               FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             pio_irq,
  output logic [1:0]       pio_address,
  output logic             pio_chipselect,
  output logic             pio_write_n,
  output logic [31:0]      pio_writedata,
  input  logic [31:0]      pio_readdata,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_edges,
  output logic [WIDTH-1:0] evt_data,
`ifdef PIO_EVT_TIMESTAMP_EN
  output logic [15:0]      evt_time,
`endif
  output logic             overflow,
  input  logic             ovf_clr,
  output logic             busy
);

  state_t           state, state_next;
  logic [WIDTH-1:0] edge_reg;
  logic             cs_c, wr_n_c, push_req, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [1:0]       addr_c;
  logic [31:0]      wdata_c;
  logic             unused_readdata;

  assign unused_readdata = ^pio_readdata[31:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= INIT;
    else       state <= state_next;
  end

  // Bus strobes are decoded from the state; push_req marks a real (non-spurious) capture.
  always_comb begin
    state_next = state;
    cs_c       = 1'b0;
    wr_n_c     = 1'b1;
    addr_c     = PIO_ADDR_DATA;
    wdata_c    = '0;
    push_req   = 1'b0;
    case (state)
      INIT: begin
        cs_c       = 1'b1;
        wr_n_c     = 1'b0;
        addr_c     = PIO_ADDR_MASK;
        wdata_c    = 32'(IRQ_MASK);
        state_next = IDLE;
      end
      IDLE: if (en && pio_irq) state_next = RD_EDGE;
      RD_EDGE: begin
        cs_c       = 1'b1;
        addr_c     = PIO_ADDR_EDGE;
        state_next = CAP_EDGE;
      end
      CAP_EDGE: begin
        addr_c     = PIO_ADDR_EDGE;
        state_next = CLR_EDGE;
      end
      CLR_EDGE: begin
        cs_c       = 1'b1;
        wr_n_c     = 1'b0;
        addr_c     = PIO_ADDR_EDGE;
        wdata_c    = 32'(edge_reg);
        state_next = RD_DATA;
      end
      RD_DATA: begin
        cs_c       = 1'b1;
        state_next = CAP_DATA;
      end
      CAP_DATA: begin
        push_req   = |(edge_reg & IRQ_MASK);
        state_next = IDLE;
      end
      default: state_next = INIT;
    endcase
  end

  // Reset releases the bus at once, even though the state register already sits in INIT.
  assign pio_chipselect = cs_c & ~reset;
  assign pio_write_n    = wr_n_c | reset;
  assign pio_address    = reset ? 2'd0 : addr_c;
  assign pio_writedata  = reset ? 32'd0 : wdata_c;
  assign busy           = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  edge_reg <= '0;
    else if (state == CAP_EDGE) edge_reg <= pio_readdata[WIDTH-1:0];
  end

  assign fifo_pop  = evt_valid & evt_ready;
  assign fifo_push = push_req;
  assign evt_valid = ~fifo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                 overflow <= 1'b0;
    else if (ovf_clr)                          overflow <= 1'b0;
    else if (push_req && fifo_full && !fifo_pop) overflow <= 1'b1;
  end

`ifdef PIO_EVT_TIMESTAMP_EN
  localparam int EW = 2 * WIDTH + 16;
  logic [15:0] cycle_cnt, ts_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
      ts_reg    <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 16'd1;
      if (state == IDLE && state_next == RD_EDGE) ts_reg <= cycle_cnt;
    end
  end

  logic [EW-1:0] fifo_din, fifo_dout;
  assign fifo_din = {ts_reg, edge_reg, pio_readdata[WIDTH-1:0]};
  assign {evt_time, evt_edges, evt_data} = fifo_dout;
`else
  localparam int EW = 2 * WIDTH;
  logic [EW-1:0] fifo_din, fifo_dout;
  assign fifo_din = {edge_reg, pio_readdata[WIDTH-1:0]};
  assign {evt_edges, evt_data} = fifo_dout;
`endif

  pio_evt_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_pio_event_sequencer.sv
// Self-checking bench: emulated edge-capture PIO, queue-based event model and directed scenarios.
module tb_pio_event_sequencer;

  localparam int         WIDTH = 10;
  localparam int         DEPTH = 4;
  localparam logic [9:0] MASK  = 10'h3FF;

  logic        clk, reset, en, pio_irq, evt_ready, ovf_clr;
  logic [1:0]  pio_address;
  logic        pio_chipselect, pio_write_n, evt_valid, overflow, busy;
  logic [31:0] pio_writedata, pio_readdata;
  logic [9:0]  evt_edges, evt_data;
`ifdef PIO_EVT_TIMESTAMP_EN
  logic [15:0] evt_time;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pio_event_sequencer #(
    .WIDTH      (WIDTH),
    .IRQ_MASK   (MASK),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .pio_irq        (pio_irq),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .pio_readdata   (pio_readdata),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_edges      (evt_edges),
    .evt_data       (evt_data),
`ifdef PIO_EVT_TIMESTAMP_EN
    .evt_time       (evt_time),
`endif
    .overflow       (overflow),
    .ovf_clr        (ovf_clr),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Emulated PIO slave: edge capture register, irq mask, registered readdata.
  logic [31:0] pio_mask_reg;
  logic [9:0]  edge_cap, inject, data_in, pio_clr;
  logic [31:0] pio_rd;
  logic        force_irq;

  assign pio_readdata = pio_rd;
  assign pio_irq      = (|(edge_cap & pio_mask_reg[9:0])) | force_irq;
  assign pio_clr      = (pio_chipselect && !pio_write_n && pio_address == 2'd3) ? pio_writedata[9:0] : 10'd0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pio_mask_reg <= '0;
      edge_cap     <= '0;
      pio_rd       <= '0;
    end else begin
      if (pio_chipselect && !pio_write_n && pio_address == 2'd2) pio_mask_reg <= pio_writedata;
      edge_cap <= (edge_cap & ~pio_clr) | inject;
      if (pio_chipselect && pio_write_n) begin
        case (pio_address)
          2'd0:    pio_rd <= {22'd0, data_in};
          2'd2:    pio_rd <= pio_mask_reg;
          2'd3:    pio_rd <= {22'd0, edge_cap};
          default: pio_rd <= '0;
        endcase
      end
    end
  end

  // Behavioural model: service step number (-1 mask write, 0 idle, 1..5 service) and an event queue.
  logic [19:0] mq[$];
  int          step  = -1;
  bit          movf  = 1'b0;
  logic [9:0]  m_edge = '0;
  bit          m_pop, m_push_req, m_drop;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        step   = -1;
        mq.delete();
        movf   = 1'b0;
        m_edge = '0;
      end else begin
        m_pop      = (mq.size() > 0) && evt_ready;
        m_push_req = (step == 5) && ((m_edge & MASK) != 10'd0);
        m_drop     = 1'b0;
        if (m_pop) void'(mq.pop_front());
        if (m_push_req) begin
          if (mq.size() < DEPTH) mq.push_back({m_edge, pio_rd[9:0]});
          else                   m_drop = 1'b1;
        end
        if (ovf_clr)     movf = 1'b0;
        else if (m_drop) movf = 1'b1;
        if (step == 2) m_edge = pio_rd[9:0];
        if (step == -1)                 step = 0;
        else if (step == 0)             step = (en && pio_irq) ? 1 : 0;
        else if (step == 5)             step = 0;
        else                            step = step + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle compare of every output against the model.
  logic        e_cs, e_wr;
  logic [1:0]  e_addr;
  logic [31:0] e_wd;
  logic [19:0] e_head;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        checkOutput("rst_cs", {31'd0, pio_chipselect}, 32'd0);
        checkOutput("rst_wr_n", {31'd0, pio_write_n}, 32'd1);
        checkOutput("rst_addr", {30'd0, pio_address}, 32'd0);
        checkOutput("rst_wdata", pio_writedata, 32'd0);
        checkOutput("rst_valid", {31'd0, evt_valid}, 32'd0);
        checkOutput("rst_edges", {22'd0, evt_edges}, 32'd0);
        checkOutput("rst_data", {22'd0, evt_data}, 32'd0);
        checkOutput("rst_ovf", {31'd0, overflow}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd1);
      end else begin
        e_cs = 1'b0; e_wr = 1'b1; e_addr = 2'd0; e_wd = 32'd0;
        case (step)
          -1: begin e_cs = 1'b1; e_wr = 1'b0; e_addr = 2'd2; e_wd = {22'd0, MASK}; end
          1:  begin e_cs = 1'b1; e_addr = 2'd3; end
          2:  e_addr = 2'd3;
          3:  begin e_cs = 1'b1; e_wr = 1'b0; e_addr = 2'd3; e_wd = {22'd0, m_edge}; end
          4:  e_cs = 1'b1;
          default: ;
        endcase
        e_head = (mq.size() > 0) ? mq[0] : 20'd0;
        checkOutput("cs", {31'd0, pio_chipselect}, {31'd0, e_cs});
        checkOutput("wr_n", {31'd0, pio_write_n}, {31'd0, e_wr});
        checkOutput("addr", {30'd0, pio_address}, {30'd0, e_addr});
        checkOutput("wdata", pio_writedata, e_wd);
        checkOutput("busy", {31'd0, busy}, {31'd0, (step != 0)});
        checkOutput("evt_valid", {31'd0, evt_valid}, {31'd0, (mq.size() > 0)});
        checkOutput("evt_edges", {22'd0, evt_edges}, {22'd0, e_head[19:10]});
        checkOutput("evt_data", {22'd0, evt_data}, {22'd0, e_head[9:0]});
        checkOutput("overflow", {31'd0, overflow}, {31'd0, movf});
      end
    end
  end

  // Raises edge bits in the PIO for one cycle; returns in the cycle where the DUT first sees irq.
  task automatic applyStimulus(input logic [9:0] edges, input logic [9:0] level);
    @(negedge clk);
    data_in = level;
    inject  = edges;
    @(negedge clk);
    inject = '0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; evt_ready = 1'b0; ovf_clr = 1'b0;
    inject = '0; data_in = '0; force_irq = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("init_cs", {31'd0, pio_chipselect}, 32'd1);
    checkOutput("init_wr_n", {31'd0, pio_write_n}, 32'd0);
    checkOutput("init_addr", {30'd0, pio_address}, 32'd2);
    checkOutput("init_wdata", pio_writedata, 32'h3FF);
    @(negedge clk);
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("idle_cs", {31'd0, pio_chipselect}, 32'd0);

    // Single event: clear write at t+3, event visible at t+6.
    applyStimulus(10'h004, 10'h2A5);
    repeat (3) @(negedge clk);
    checkOutput("t3_wr_n", {31'd0, pio_write_n}, 32'd0);
    checkOutput("t3_addr", {30'd0, pio_address}, 32'd3);
    checkOutput("t3_wdata", pio_writedata, 32'h004);
    repeat (2) @(negedge clk);
    checkOutput("t5_valid", {31'd0, evt_valid}, 32'd0);
    @(negedge clk);
    checkOutput("t6_valid", {31'd0, evt_valid}, 32'd1);
    checkOutput("t6_edges", {22'd0, evt_edges}, 32'h004);
    checkOutput("t6_data", {22'd0, evt_data}, 32'h2A5);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    checkOutput("drained", {31'd0, evt_valid}, 32'd0);

    // Five events with no consumer: four held, fifth dropped.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(10'h001 << i, 10'h100 + 10'(i));
      repeat (7) @(negedge clk);
    end
    checkOutput("ovf_set", {31'd0, overflow}, 32'd1);
    checkOutput("full_head_edges", {22'd0, evt_edges}, 32'h001);
    checkOutput("full_head_data", {22'd0, evt_data}, 32'h100);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    checkOutput("ovf_clr", {31'd0, overflow}, 32'd0);

    // Push while full with a simultaneous pop.
    applyStimulus(10'h020, 10'h155);
    repeat (5) @(negedge clk);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    checkOutput("pp_ovf", {31'd0, overflow}, 32'd0);
    checkOutput("pp_head_edges", {22'd0, evt_edges}, 32'h002);
    checkOutput("pp_head_data", {22'd0, evt_data}, 32'h101);
    evt_ready = 1'b1;
    repeat (4) @(negedge clk);
    evt_ready = 1'b0;
    checkOutput("pp_empty", {31'd0, evt_valid}, 32'd0);

    // Spurious irq: clear write of zero, no event.
    @(negedge clk);
    force_irq = 1'b1;
    @(negedge clk);
    force_irq = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("spur_wr_n", {31'd0, pio_write_n}, 32'd0);
    checkOutput("spur_wdata", pio_writedata, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("spur_valid", {31'd0, evt_valid}, 32'd0);

    // en low holds off service until re-enabled.
    en = 1'b0;
    applyStimulus(10'h040, 10'h0AA);
    repeat (6) @(negedge clk);
    checkOutput("en_off_busy", {31'd0, busy}, 32'd0);
    en = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("en_on_edges", {22'd0, evt_edges}, 32'h040);
    checkOutput("en_on_data", {22'd0, evt_data}, 32'h0AA);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;

    // Reset during RD_DATA with two events queued.
    applyStimulus(10'h080, 10'h011);
    repeat (7) @(negedge clk);
    applyStimulus(10'h200, 10'h022);
    repeat (7) @(negedge clk);
    applyStimulus(10'h100, 10'h033);
    repeat (4) @(negedge clk);
    checkOutput("pre_rst_cs", {31'd0, pio_chipselect}, 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("mid_rst_cs", {31'd0, pio_chipselect}, 32'd0);
    checkOutput("mid_rst_valid", {31'd0, evt_valid}, 32'd0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("reinit_cs", {31'd0, pio_chipselect}, 32'd1);
    checkOutput("reinit_addr", {30'd0, pio_address}, 32'd2);
    checkOutput("reinit_wdata", pio_writedata, 32'h3FF);
    repeat (3) @(negedge clk);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
